// File: rtl/retire_rob.sv
// retire_rob: in-order reorder buffer that allocates entries at dispatch,
// marks them done on completion, and retires one done head entry per cycle,
// returning the superseded physical tag to the free pool.
//
// Optional feature: define ROB_FLUSH_EN to add the flush input.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   disp_valid / disp_ready        dispatch handshake (ready = !full)
//   disp_reg_write, disp_rd,
//   disp_rrd, disp_old_tag         dispatched entry payload
//   disp_idx                       index allocated to the offered entry (tail)
//   cmpl_valid, cmpl_idx           execution-done mark
//   push_free_reg, freed_reg       tag returned to the free pool on retire
//   retire_valid, retire_rd,
//   retire_rrd                     commit report (combinational, from head)
//   count, empty, full             occupancy
//   flush (ROB_FLUSH_EN only)      discard all entries at the next edge
module retire_rob #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned PREG_WIDTH = 6,
    parameter int unsigned AREG_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef ROB_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic                       disp_reg_write,
    input  logic [AREG_WIDTH-1:0]      disp_rd,
    input  logic [PREG_WIDTH-1:0]      disp_rrd,
    input  logic [PREG_WIDTH-1:0]      disp_old_tag,
    output logic [$clog2(DEPTH)-1:0]   disp_idx,
    input  logic                       cmpl_valid,
    input  logic [$clog2(DEPTH)-1:0]   cmpl_idx,
    output logic                       push_free_reg,
    output logic [PREG_WIDTH-1:0]      freed_reg,
    output logic                       retire_valid,
    output logic [AREG_WIDTH-1:0]      retire_rd,
    output logic [PREG_WIDTH-1:0]      retire_rrd,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    // Per-entry state
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      done_q,  done_d;
    logic [DEPTH-1:0]      rw_q,    rw_d;
    logic [AREG_WIDTH-1:0] rd_q    [DEPTH];
    logic [AREG_WIDTH-1:0] rd_d    [DEPTH];
    logic [PREG_WIDTH-1:0] rrd_q   [DEPTH];
    logic [PREG_WIDTH-1:0] rrd_d   [DEPTH];
    logic [PREG_WIDTH-1:0] old_q   [DEPTH];
    logic [PREG_WIDTH-1:0] old_d   [DEPTH];

    // Pointers and occupancy
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full_w;
    logic disp_fire;
    logic retire_w;
    logic flush_w;

`ifdef ROB_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Occupancy flags come straight from the registered count
    assign full_w     = (count_q == CNT_W'(DEPTH));
    assign full       = full_w;
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign disp_ready = !full_w;
    assign disp_idx   = tail_q;

    // No retire-bypass into a full ROB; reset suppresses the retire so no tag escapes
    assign disp_fire = disp_valid && !full_w;
    assign retire_w  = valid_q[head_q] && done_q[head_q] && !rst;

    // Retire report and tag return; a reg_write to x0 frees the unmapped new tag
    always_comb begin
        retire_valid  = retire_w;
        retire_rd     = '0;
        retire_rrd    = '0;
        push_free_reg = 1'b0;
        freed_reg     = '0;
        if (retire_w) begin
            retire_rd     = rd_q[head_q];
            retire_rrd    = rrd_q[head_q];
            push_free_reg = rw_q[head_q];
            if (rw_q[head_q]) begin
                freed_reg = (rd_q[head_q] != '0) ? old_q[head_q] : rrd_q[head_q];
            end
        end
    end

    // Next-state: completion, retire, dispatch, then flush overriding all
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        rw_d    = rw_q;
        rd_d    = rd_q;
        rrd_d   = rrd_q;
        old_d   = old_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        // Only valid entries can be marked; the tail slot is invalid before its dispatch edge
        if (cmpl_valid && valid_q[cmpl_idx]) begin
            done_d[cmpl_idx] = 1'b1;
        end

        if (retire_w) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            head_d          = IDX_W'(head_q + IDX_W'(1));
        end

        if (disp_fire) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            rw_d[tail_q]    = disp_reg_write;
            rd_d[tail_q]    = disp_rd;
            rrd_d[tail_q]   = disp_rrd;
            old_d[tail_q]   = disp_old_tag;
            tail_d          = IDX_W'(tail_q + IDX_W'(1));
        end

        count_d = CNT_W'(count_q + CNT_W'(disp_fire) - CNT_W'(retire_w));

        if (flush_w) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage; only meaningful while the entry is valid
    always_ff @(posedge clk) begin
        rw_q  <= rw_d;
        rd_q  <= rd_d;
        rrd_q <= rrd_d;
        old_q <= old_d;
    end

endmodule

// File: tb/tb_retire_rob.sv
// Directed self-checking bench for retire_rob (default DEPTH=16).
module tb_retire_rob;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       disp_valid;
    logic       disp_ready;
    logic       disp_reg_write;
    logic [4:0] disp_rd;
    logic [5:0] disp_rrd;
    logic [5:0] disp_old_tag;
    logic [3:0] disp_idx;
    logic       cmpl_valid;
    logic [3:0] cmpl_idx;
    logic       push_free_reg;
    logic [5:0] freed_reg;
    logic       retire_valid;
    logic [4:0] retire_rd;
    logic [5:0] retire_rrd;
    logic [4:0] count;
    logic       empty;
    logic       full;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    retire_rob dut (
        .clk            (clk),
        .rst            (rst),
`ifdef ROB_FLUSH_EN
        .flush          (flush),
`endif
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_reg_write (disp_reg_write),
        .disp_rd        (disp_rd),
        .disp_rrd       (disp_rrd),
        .disp_old_tag   (disp_old_tag),
        .disp_idx       (disp_idx),
        .cmpl_valid     (cmpl_valid),
        .cmpl_idx       (cmpl_idx),
        .push_free_reg  (push_free_reg),
        .freed_reg      (freed_reg),
        .retire_valid   (retire_valid),
        .retire_rd      (retire_rd),
        .retire_rrd     (retire_rrd),
        .count          (count),
        .empty          (empty),
        .full           (full)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [4:0] rd, input logic [5:0] rrd,
                            input logic [5:0] old, input logic rw);
        disp_valid     = 1'b1;
        disp_rd        = rd;
        disp_rrd       = rrd;
        disp_old_tag   = old;
        disp_reg_write = rw;
        tick();
        disp_valid     = 1'b0;
    endtask

    task automatic complete(input logic [3:0] idx);
        cmpl_valid = 1'b1;
        cmpl_idx   = idx;
        tick();
        cmpl_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_reg_write = 1'b0;
        disp_rd = '0; disp_rrd = '0; disp_old_tag = '0; cmpl_valid = 1'b0; cmpl_idx = '0;
        tick();
        do_reset();

        // Reset state
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ready", 32'(disp_ready), 32'd1);
        check("rst_idx", 32'(disp_idx), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_retire", 32'(retire_valid), 32'd0);
        check("rst_push", 32'(push_free_reg), 32'd0);
        check("rst_freed", 32'(freed_reg), 32'd0);

        // Minimum latency: dispatch, complete next cycle, retire visible after that edge
        dispatch(5'd5, 6'd32, 6'd5, 1'b1);
        check("lat_count1", 32'(count), 32'd1);
        check("lat_idx1", 32'(disp_idx), 32'd1);
        check("lat_noret", 32'(retire_valid), 32'd0);
        complete(4'd0);
        check("lat_retire", 32'(retire_valid), 32'd1);
        check("lat_push", 32'(push_free_reg), 32'd1);
        check("lat_freed", 32'(freed_reg), 32'd5);
        check("lat_rd", 32'(retire_rd), 32'd5);
        check("lat_rrd", 32'(retire_rrd), 32'd32);
        tick();
        check("lat_after_ret", 32'(retire_valid), 32'd0);
        check("lat_empty", 32'(empty), 32'd1);

        // rd=0 frees the new tag; store frees nothing; dispatch+retire keeps count
        check("x0_idx", 32'(disp_idx), 32'd1);
        dispatch(5'd0, 6'd40, 6'd7, 1'b1);
        complete(4'd1);
        check("x0_push", 32'(push_free_reg), 32'd1);
        check("x0_freed", 32'(freed_reg), 32'd40);
        dispatch(5'd3, 6'd7, 6'd9, 1'b0);
        check("simul_count", 32'(count), 32'd1);
        check("simul_idx", 32'(disp_idx), 32'd3);
        complete(4'd2);
        check("st_retire", 32'(retire_valid), 32'd1);
        check("st_push", 32'(push_free_reg), 32'd0);
        check("st_freed", 32'(freed_reg), 32'd0);
        check("st_rd", 32'(retire_rd), 32'd3);
        tick();
        check("st_empty", 32'(empty), 32'd1);

        // Out-of-order completion, in-order retire (entries at idx 3,4,5)
        dispatch(5'd1, 6'd11, 6'd21, 1'b1);
        dispatch(5'd2, 6'd12, 6'd22, 1'b1);
        dispatch(5'd3, 6'd13, 6'd23, 1'b1);
        check("ooo_count", 32'(count), 32'd3);
        complete(4'd5);
        check("ooo_wait5", 32'(retire_valid), 32'd0);
        complete(4'd4);
        check("ooo_wait4", 32'(retire_valid), 32'd0);
        complete(4'd3);
        check("ooo_r0", 32'(retire_valid), 32'd1);
        check("ooo_r0_freed", 32'(freed_reg), 32'd21);
        tick();
        check("ooo_r1", 32'(retire_valid), 32'd1);
        check("ooo_r1_freed", 32'(freed_reg), 32'd22);
        tick();
        check("ooo_r2", 32'(retire_valid), 32'd1);
        check("ooo_r2_freed", 32'(freed_reg), 32'd23);
        check("ooo_r2_rd", 32'(retire_rd), 32'd3);
        tick();
        check("ooo_done", 32'(retire_valid), 32'd0);
        check("ooo_empty", 32'(empty), 32'd1);

        // Fill to full, reject extra offer, retire one, wrap dispatch to idx0
        do_reset();
        for (int i = 0; i < 16; i++) begin
            dispatch(5'(i + 1), 6'(i + 32), 6'(i), 1'b1);
        end
        check("full_full", 32'(full), 32'd1);
        check("full_ready", 32'(disp_ready), 32'd0);
        check("full_count", 32'(count), 32'd16);
        disp_valid = 1'b1; disp_rd = 5'd9; disp_rrd = 6'd50; disp_old_tag = 6'd9; disp_reg_write = 1'b1;
        tick();
        check("full_17_count", 32'(count), 32'd16);
        check("full_17_idx", 32'(disp_idx), 32'd0);
        cmpl_valid = 1'b1; cmpl_idx = 4'd0;
        tick();
        cmpl_valid = 1'b0;
        check("full_ret", 32'(retire_valid), 32'd1);
        check("full_ret_rrd", 32'(retire_rrd), 32'd32);
        check("full_ret_freed", 32'(freed_reg), 32'd0);
        check("full_nobypass", 32'(disp_ready), 32'd0);
        tick();
        check("full_after_count", 32'(count), 32'd15);
        check("full_wrap_idx", 32'(disp_idx), 32'd0);
        check("full_after_ready", 32'(disp_ready), 32'd1);
        tick();
        disp_valid = 1'b0;
        check("wrap_count", 32'(count), 32'd16);
        check("wrap_idx", 32'(disp_idx), 32'd1);

        // Completion to invalid slots; reset with pending entries
        do_reset();
        complete(4'd3);
        check("inv_empty_count", 32'(count), 32'd0);
        check("inv_empty_ret", 32'(retire_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            dispatch(5'(i + 1), 6'(i + 40), 6'(i + 1), 1'b1);
        end
        complete(4'd7);
        check("inv_count", 32'(count), 32'd5);
        check("inv_ret", 32'(retire_valid), 32'd0);
        complete(4'd0);
        check("pend_ret", 32'(retire_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rstpend_push", 32'(push_free_reg), 32'd0);
        tick();
        rst = 1'b0;
        check("rstpend_count", 32'(count), 32'd0);
        check("rstpend_empty", 32'(empty), 32'd1);
        check("rstpend_push2", 32'(push_free_reg), 32'd0);
        check("rstpend_ret", 32'(retire_valid), 32'd0);

`ifdef ROB_FLUSH_EN
        // Flush with a done head: head still retires, queue then empties
        for (int i = 0; i < 4; i++) begin
            dispatch(5'(i + 1), 6'(i + 20), 6'(i + 10), 1'b1);
        end
        complete(4'd0);
        flush = 1'b1;
        disp_valid = 1'b1;
        #1;
        check("fl_ret", 32'(retire_valid), 32'd1);
        check("fl_freed", 32'(freed_reg), 32'd10);
        tick();
        flush = 1'b0;
        disp_valid = 1'b0;
        check("fl_count", 32'(count), 32'd0);
        check("fl_idx", 32'(disp_idx), 32'd0);
        check("fl_empty", 32'(empty), 32'd1);
        check("fl_noret", 32'(retire_valid), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
